// File: rtl/spi_read_sequencer.sv
// AXI4-Lite read-channel master: one start pulse runs a scan of single-beat word reads,
// one outstanding at a time, streaming each returned word out with a one-cycle strobe.
module spi_read_sequencer #(
  parameter int ADDR_SIZE = 24,
  parameter int DATA_SIZE = 32,
  parameter int CNT_SIZE  = 16,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_SIZE-1:0] base_addr,
  input  logic [CNT_SIZE-1:0]  word_count,
  output logic                 busy,
  output logic                 done,
  output logic                 err_resp,
  output logic                 err_tmo,
  output logic                 word_valid,
  output logic [DATA_SIZE-1:0] word_data,
  output logic [CNT_SIZE-1:0]  word_index,
  output logic [ADDR_SIZE-1:0] araddr,
  output logic                 arvalid,
  input  logic                 arready,
  input  logic [DATA_SIZE-1:0] rdata,
  input  logic [1:0]           rresp,
  input  logic                 rvalid,
  output logic                 rready
);

  localparam int STRIDE = DATA_SIZE / 8;
  localparam int TW     = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t               state, state_next;
  logic [ADDR_SIZE-1:0] addr_reg;
  logic [CNT_SIZE-1:0]  count_reg;
  logic [CNT_SIZE-1:0]  idx_reg;
  logic [TW-1:0]        tmo_reg;
  logic                 abort_pend;
  logic                 ar_hs, r_hs, tmo_hit, last_word, stop_after_read;

  // Handshake-facing outputs are decoded from state so reset clears them immediately.
  assign arvalid = (state == ADDR);
  assign rready  = (state == DATA);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign araddr  = addr_reg;

  assign ar_hs     = arvalid & arready;
  assign r_hs      = rvalid & rready;
  assign tmo_hit   = (tmo_reg == TW'(TIMEOUT - 1));
  assign last_word = (idx_reg == count_reg - CNT_SIZE'(1));
  assign stop_after_read = (rresp != 2'b00) || last_word || abort_pend || abort;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (word_count == '0) ? DONE : ADDR;
      // A handshake already presented this cycle wins over abort or timeout.
      ADDR: begin
        if (ar_hs)        state_next = DATA;
        else if (abort)   state_next = DONE;
        else if (tmo_hit) state_next = DONE;
      end
      DATA: begin
        if (r_hs)         state_next = stop_after_read ? DONE : ADDR;
        else if (tmo_hit) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state      <= IDLE;
      addr_reg   <= '0;
      count_reg  <= '0;
      idx_reg    <= '0;
      tmo_reg    <= '0;
      abort_pend <= 1'b0;
      err_resp   <= 1'b0;
      err_tmo    <= 1'b0;
      word_valid <= 1'b0;
      word_data  <= '0;
      word_index <= '0;
    end else begin
      state      <= state_next;
      word_valid <= 1'b0;

      if (state != state_next)                   tmo_reg <= '0;
      else if (state == ADDR || state == DATA)   tmo_reg <= tmo_reg + TW'(1);

      if ((state == ADDR || state == DATA) && abort) abort_pend <= 1'b1;

      case (state)
        IDLE: if (start) begin
          addr_reg   <= base_addr;
          count_reg  <= word_count;
          idx_reg    <= '0;
          abort_pend <= 1'b0;
          err_resp   <= 1'b0;
          err_tmo    <= 1'b0;
        end
        ADDR: if (!ar_hs && !abort && tmo_hit) err_tmo <= 1'b1;
        DATA: begin
          if (r_hs) begin
            word_data  <= rdata;
            word_index <= idx_reg;
            word_valid <= 1'b1;
            if (rresp != 2'b00) err_resp <= 1'b1;
            if (!stop_after_read) begin
              idx_reg  <= idx_reg + CNT_SIZE'(1);
              addr_reg <= addr_reg + ADDR_SIZE'(STRIDE);
            end
          end else if (tmo_hit) begin
            err_tmo <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_read_sequencer.sv
// Randomized bench: a scripted AXI read slave feeds the sequencer, and a per-scan plan is
// turned into the expected address/word/flag outcome by a list-level reference model.
`timescale 1ns/1ps
module tb_spi_read_sequencer;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        ARESET = 1'b1;
  logic        start = 1'b0, abort = 1'b0;
  logic [23:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic        busy, done, err_resp, err_tmo, word_valid;
  logic [31:0] word_data;
  logic [15:0] word_index;
  logic [23:0] araddr;
  logic        arvalid, arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0, rready;

  spi_read_sequencer #(.ADDR_SIZE(24), .DATA_SIZE(32), .CNT_SIZE(16), .TIMEOUT(TMO)) dut (
    .ACLK(clk), .ARESET(ARESET), .start(start), .abort(abort),
    .base_addr(base_addr), .word_count(word_count),
    .busy(busy), .done(done), .err_resp(err_resp), .err_tmo(err_tmo),
    .word_valid(word_valid), .word_data(word_data), .word_index(word_index),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Slave plan per word: handshake delays (>= TMO means never), response code, abort injection.
  int       dly_ar[16], dly_r[16];
  bit [1:0] resp_plan[16];
  bit       abort_a[16], abort_r[16];

  logic [23:0] obs_addr[$];
  logic [31:0] obs_data[$];
  logic [15:0] obs_idx[$];
  int          busy_cyc, ar_cyc, done_cnt, k, ar_wait, r_wait;
  bit          in_r, got_resp, got_tmo;
  logic [23:0] cur_addr;

  function automatic logic [31:0] mem_word(input logic [23:0] a);
    return {a[7:0] ^ 8'h3C, a};
  endfunction

  task automatic clear_plan();
    for (int i = 0; i < 16; i++) begin
      dly_ar[i] = 0; dly_r[i] = 0; resp_plan[i] = 2'b00; abort_a[i] = 0; abort_r[i] = 0;
    end
  endtask

  task automatic random_plan();
    for (int i = 0; i < 16; i++) begin
      dly_ar[i]    = ($urandom_range(0, 24) == 0) ? 20 : int'($urandom_range(0, 3));
      dly_r[i]     = ($urandom_range(0, 24) == 0) ? 20 : int'($urandom_range(0, 4));
      resp_plan[i] = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      abort_r[i]   = ($urandom_range(0, 11) == 0);
      abort_a[i]   = ($urandom_range(0, 14) == 0);
      if (abort_a[i] && dly_ar[i] == 0) dly_ar[i] = 1;
    end
  endtask

  // One negedge: record DUT activity, then choose slave inputs for the next rising edge.
  task automatic step(input int cyc);
    start = 1'b0;
    if (word_valid) begin obs_idx.push_back(word_index); obs_data.push_back(word_data); end
    if (busy)    busy_cyc++;
    if (arvalid) ar_cyc++;
    if (done) begin
      done_cnt++;
      got_resp = err_resp;
      got_tmo  = err_tmo;
      chk("busy_at_done", 64'(busy), 64'd1);
      chk("rready_at_done", 64'(rready), 64'd0);
    end
    if (cyc == 2 && busy) begin
      start = 1'b1;
      base_addr = 24'($urandom);
      word_count = 16'($urandom_range(1, 9));
    end
    arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = '0; abort = 1'b0;
    if (k < 16) begin
      if (!in_r) begin
        if (abort_a[k] && ar_wait == 0 && arvalid) abort = 1'b1;
        if (arvalid && ar_wait == dly_ar[k]) begin
          arready = 1'b1;
          obs_addr.push_back(araddr);
          cur_addr = araddr;
          in_r = 1'b1;
          r_wait = 0;
        end else if (arvalid) begin
          ar_wait++;
        end
      end else begin
        if (abort_r[k] && r_wait == 0) abort = 1'b1;
        if (r_wait == dly_r[k]) begin
          rvalid = 1'b1;
          rdata = mem_word(cur_addr);
          rresp = resp_plan[k];
          in_r = 1'b0;
          ar_wait = 0;
          k++;
        end else begin
          r_wait++;
        end
      end
    end
  endtask

  task automatic run_scan(input string name, input logic [23:0] b, input logic [15:0] c);
    logic [23:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [23:0] a;
    bit e_resp, e_tmo;
    int cyc, post;
    e_resp = 0; e_tmo = 0;
    // Reference outcome: walk the plan word by word and stop at the first terminating event.
    for (int i = 0; i < int'(c) && i < 16; i++) begin
      if (abort_a[i]) break;
      if (dly_ar[i] >= TMO) begin e_tmo = 1; break; end
      a = b + 24'(4 * i);
      exp_addr.push_back(a);
      if (dly_r[i] >= TMO) begin e_tmo = 1; break; end
      exp_data.push_back(mem_word(a));
      if (resp_plan[i] != 2'b00) begin e_resp = 1; break; end
      if (abort_r[i]) break;
    end

    obs_addr.delete(); obs_data.delete(); obs_idx.delete();
    busy_cyc = 0; ar_cyc = 0; done_cnt = 0; k = 0; ar_wait = 0; r_wait = 0; in_r = 0;
    got_resp = 0; got_tmo = 0;

    @(negedge clk); base_addr = b; word_count = c; start = 1'b1;
    @(negedge clk);
    cyc = 0; post = 0;
    while (post < 25 && cyc < 3000) begin
      step(cyc);
      if (done_cnt > 0) post++;
      cyc++;
      @(negedge clk);
    end

    chk({name, ".done_cnt"}, 64'(done_cnt), 64'd1);
    chk({name, ".n_addr"}, 64'(obs_addr.size()), 64'(exp_addr.size()));
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++)
      chk($sformatf("%s.araddr[%0d]", name, i), 64'(obs_addr[i]), 64'(exp_addr[i]));
    chk({name, ".n_words"}, 64'(obs_data.size()), 64'(exp_data.size()));
    for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
      chk($sformatf("%s.word_data[%0d]", name, i), 64'(obs_data[i]), 64'(exp_data[i]));
      chk($sformatf("%s.word_index[%0d]", name, i), 64'(obs_idx[i]), 64'(i));
    end
    chk({name, ".err_resp"}, 64'(got_resp), 64'(e_resp));
    chk({name, ".err_tmo"}, 64'(got_tmo), 64'(e_tmo));
    chk({name, ".err_resp_hold"}, 64'(err_resp), 64'(e_resp));
    chk({name, ".err_tmo_hold"}, 64'(err_tmo), 64'(e_tmo));
    chk({name, ".idle_busy"}, 64'(busy), 64'd0);
    if (c == 16'd0) begin
      chk({name, ".busy_cycles"}, 64'(busy_cyc), 64'd1);
      chk({name, ".ar_cycles"}, 64'(ar_cyc), 64'd0);
    end
    $display("scan %s base=%06h count=%0d addrs=%0d words=%0d err_resp=%0d err_tmo=%0d",
             name, b, c, obs_addr.size(), obs_data.size(), got_resp, got_tmo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.arvalid", 64'(arvalid), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.word_valid", 64'(word_valid), 64'd0);
    chk("rst.araddr", 64'(araddr), 64'd0);
    ARESET = 1'b0;

    clear_plan();
    run_scan("t1_basic", 24'h000100, 16'd3);
    clear_plan();
    run_scan("t2_zero", 24'h000200, 16'd0);
    clear_plan();
    run_scan("t3_wrap", 24'hFFFFFC, 16'd2);
    clear_plan(); resp_plan[1] = 2'b10;
    run_scan("t4_resp", 24'h001000, 16'd4);
    clear_plan(); dly_r[0] = 40;
    run_scan("t5_tmo_r", 24'h002000, 16'd2);
    clear_plan(); dly_ar[1] = 40;
    run_scan("t5_tmo_ar", 24'h002100, 16'd3);
    clear_plan(); abort_r[0] = 1; dly_r[0] = 3;
    run_scan("t6_abort_r", 24'h003000, 16'd5);
    clear_plan(); abort_a[1] = 1; dly_ar[1] = 2;
    run_scan("t6_abort_a", 24'h003100, 16'd5);

    // Reset mid-ADDR: arready withheld so the DUT sits in ADDR when reset hits.
    @(negedge clk); base_addr = 24'h004000; word_count = 16'd4; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("mid.arvalid_before", 64'(arvalid), 64'd1);
    #2 ARESET = 1'b1;
    #1;
    chk("mid.arvalid", 64'(arvalid), 64'd0);
    chk("mid.busy", 64'(busy), 64'd0);
    chk("mid.araddr", 64'(araddr), 64'd0);
    @(negedge clk); ARESET = 1'b0;
    clear_plan();
    run_scan("after_rst", 24'h004000, 16'd3);

    for (int s = 0; s < 30; s++) begin
      random_plan();
      run_scan($sformatf("rnd%0d", s), 24'($urandom),
               ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 10)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
